uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receiver: the next generation of the fixed 8N1, 16x-oversampled receiver in the serial block. Adds configurable data width, parity, stop-bit count and oversampling ratio, plus an internal sample-tick generator, an input synchroniser, an integrated output shift register and a valid/ready output handshake with parity, framing and overrun reporting. Sits between the pad-side RX line and the host-side byte consumer (FIFO or register bank).

## Interface
- BAUD_DIV, 27: clk cycles per sample tick. 50 MHz / (115200 × 16) ≈ 27. Legal range ≥ 2.
- OVERSAMPLE, 16: sample ticks per bit. Must be even and ≥ 8.
- DATA_BITS, 8: data bits per frame. Legal range 5..9.
- PARITY, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits per frame. Legal values 1 or 2.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- i_rx_d  input  1  asynchronous serial line. Idles high.
- o_data  output  DATA_BITS  received word, LSB first on the line.
- o_valid  output  1  o_data and error flags are valid.
- i_ready  input  1  consumer accepts when o_valid & i_ready.
- o_parity_err  output  1  parity mismatch for the word in o_data.
- o_frame_err  output  1  a stop bit was sampled 0 for the word in o_data.
- o_overrun  output  1  one-cycle pulse: a completed frame was dropped.
- o_busy  output  1  high while state ≠ IDLE.

## Operation
- i_rx_d passes through a 2-flop synchroniser. Only the synchronised signal (rxs) is used.
- Tick generator: a counter runs 0..BAUD_DIV-1 and pulses `tick` for one clk at wrap. It is free-running and never reset by frame events.
- Within each bit, a tick counter s_cnt runs 0..OVERSAMPLE-1. Let MID = OVERSAMPLE/2.
- Three samples are taken at s_cnt = MID-1, MID and MID+1. The bit value is the majority of the three: (a&b)|(a&c)|(b&c).
- The bit is decided on the tick where s_cnt = MID+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a tick with rxs = 0, go to START with s_cnt = 0.
  - START: if the start-bit majority = 1, return to IDLE (glitch reject; no flags, no output). Otherwise continue to DATA.
  - DATA: each decided bit shifts in LSB first. After DATA_BITS bits, go to PARITY if PARITY ≠ 0, else to STOP.
  - PARITY: expected bit = XOR of the data bits, inverted for odd parity. A mismatch latches perr.
  - STOP: each stop bit decided as 0 latches ferr. After STOP_BITS bits, go to IDLE on the decision tick. This lets a new start edge be detected in the remaining half of the stop bit.
  - Between decisions, the state advances at s_cnt wrap (OVERSAMPLE-1 → 0).
- Frame completion on the final stop decision:
  - If o_valid = 0, or o_valid & i_ready in the same cycle: load o_data, o_parity_err = perr, o_frame_err = ferr, and o_valid = 1.
  - Otherwise (o_valid = 1 and i_ready = 0): drop the new frame, keep the old word, and pulse o_overrun.
- Frames with parity or framing errors are still delivered, with their flags set.
- o_valid clears on o_valid & i_ready when no load happens in the same cycle.
- o_data and the error flags are stable while o_valid = 1 and i_ready = 0.
- A line held low (break) is delivered as data 0 with o_frame_err = 1. The receiver then stays in IDLE until rxs = 1 is seen, and only then re-arms start detection.

## Timing
- Reset values: o_data = 0, o_valid = 0, o_parity_err = 0, o_frame_err = 0, o_overrun = 0, o_busy = 0. FSM = IDLE. All counters = 0. Synchroniser flops = 1.
- Reset mid-frame: the partial frame is discarded. No o_valid and no error flag after reset release.
- Input latency: 2 clk synchroniser delay plus up to BAUD_DIV clk of detection jitter.
- Frame completion: o_valid rises 1 clk after the tick at s_cnt = MID+1 of the last stop bit.
- Default 8N1 settings (BAUD_DIV = 27, OVERSAMPLE = 16):
  - one bit = 432 clk.
  - o_valid ≈ 9 × 432 + 9 × 27 = 4131 clk after the detect tick.
- The handshake completes in the same cycle: o_valid drops on the next edge unless a load happens in that cycle.

## Test plan
- 8N1 defaults, send 0xA5 at 115200 baud with i_ready = 1 → o_data = 0xA5 and o_valid pulses once. Both error flags are 0 and o_overrun never fires.
- PARITY = 2, DATA_BITS = 7, send 0x35 with a correct even-parity bit and then with the parity bit inverted → first word has o_parity_err = 0, second word (0x35) has o_parity_err = 1.
- Send 0x3C with the stop bit forced to 0 → o_data = 0x3C with o_frame_err = 1. The next normal frame 0x11 is received cleanly.
- Drive a 4-tick low glitch on an idle line → no o_valid and o_busy returns to 0. A correct frame 0x5A sent 2 bit-times later is then received.
- Hold i_ready = 0 and send 0x01 then 0x02 back-to-back → o_data stays 0x01 and o_overrun pulses once. Raising i_ready consumes 0x01 and o_valid then falls.
- Assert rst_n = 0 in the middle of data bit 4 and release → all outputs are 0. A subsequent 0xC3 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised, oversampled RX line decoded into words
// with optional parity, 1-2 stop bits, valid/ready output and error/overrun reporting.
module uart_rx_param #(
  parameter int BAUD_DIV   = 27,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_rx_d,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_ONE     = SW'(1);
  localparam logic [SW-1:0] S_MID_M1  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_MID_P1  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = (PARITY == 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  logic                 sync1_r, sync2_r;
  logic [BW-1:0]        baud_cnt_r;
  logic [SW-1:0]        s_cnt_r;
  logic [3:0]           bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 samp_a_r, samp_b_r;
  logic                 perr_r, ferr_r, armed_r;
  state_t               state_r;
  logic                 rxs_s, tick_s, bit_s;

  assign rxs_s  = sync2_r;
  assign tick_s = (baud_cnt_r == BAUD_LAST);
  assign bit_s  = majority3(samp_a_r, samp_b_r, rxs_s);

  // Two-flop synchroniser for the asynchronous RX line (idles high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= i_rx_d;
      sync2_r <= sync1_r;
    end
  end

  // Free-running sample-tick divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt_r <= '0;
    end else if (baud_cnt_r == BAUD_LAST) begin
      baud_cnt_r <= '0;
    end else begin
      baud_cnt_r <= baud_cnt_r + BAUD_ONE;
    end
  end

  // Frame FSM, bit sampling and output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      s_cnt_r      <= '0;
      bit_cnt_r    <= 4'd0;
      shift_r      <= '0;
      samp_a_r     <= 1'b1;
      samp_b_r     <= 1'b1;
      perr_r       <= 1'b0;
      ferr_r       <= 1'b0;
      armed_r      <= 1'b1;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      // After a break, start detection waits for the line to return high
      if (!armed_r && rxs_s) begin
        armed_r <= 1'b1;
      end
      if (tick_s) begin
        case (state_r)
          ST_IDLE: begin
            if (armed_r && !rxs_s) begin
              state_r <= ST_START;
              s_cnt_r <= '0;
              o_busy  <= 1'b1;
            end
          end
          default: begin
            s_cnt_r <= (s_cnt_r == S_LAST) ? '0 : s_cnt_r + S_ONE;
            if (s_cnt_r == S_MID_M1) begin
              samp_a_r <= rxs_s;
            end
            if (s_cnt_r == S_MID) begin
              samp_b_r <= rxs_s;
            end
            if (s_cnt_r == S_MID_P1) begin
              case (state_r)
                ST_START: begin
                  if (bit_s) begin
                    state_r <= ST_IDLE;
                    o_busy  <= 1'b0;
                  end
                end
                ST_DATA: begin
                  shift_r <= {bit_s, shift_r[DATA_BITS-1:1]};
                end
                ST_PARITY: begin
                  if (bit_s != parity_bit(shift_r, ODD_PAR)) begin
                    perr_r <= 1'b1;
                  end
                end
                ST_STOP: begin
                  if (!bit_s) begin
                    ferr_r <= 1'b1;
                  end
                  if (bit_cnt_r == STOP_LAST) begin
                    state_r <= ST_IDLE;
                    o_busy  <= 1'b0;
                    armed_r <= bit_s;
                    if (!o_valid || i_ready) begin
                      o_data       <= shift_r;
                      o_parity_err <= perr_r;
                      o_frame_err  <= ferr_r | ~bit_s;
                      o_valid      <= 1'b1;
                    end else begin
                      o_overrun <= 1'b1;
                    end
                  end
                end
                default: begin
                  state_r <= ST_IDLE;
                  o_busy  <= 1'b0;
                end
              endcase
            end else if (s_cnt_r == S_LAST) begin
              case (state_r)
                ST_START: begin
                  state_r   <= ST_DATA;
                  bit_cnt_r <= 4'd0;
                  perr_r    <= 1'b0;
                  ferr_r    <= 1'b0;
                end
                ST_DATA: begin
                  if (bit_cnt_r == DATA_LAST) begin
                    bit_cnt_r <= 4'd0;
                    state_r   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                  end else begin
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                  end
                end
                ST_PARITY: begin
                  state_r   <= ST_STOP;
                  bit_cnt_r <= 4'd0;
                end
                ST_STOP: begin
                  bit_cnt_r <= bit_cnt_r + 4'd1;
                end
                default: begin
                  state_r <= ST_IDLE;
                  o_busy  <= 1'b0;
                end
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 default instance and a fast 7E1 instance.
module tb_uart_rx_param;

  localparam int BIT0 = 432;  // 27 * 16
  localparam int BIT1 = 32;   // 4 * 8

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rx0, rx1, ready0, ready1;
  logic [7:0] data0;
  logic [6:0] data1;
  logic       valid0, perr0, ferr0, ovr0, busy0;
  logic       valid1, perr1, ferr1, ovr1, busy1;

  int total = 0;
  int bad   = 0;

  uart_rx_param dut0 (
    .clk(clk), .rst_n(rst_n), .i_rx_d(rx0), .o_data(data0), .o_valid(valid0),
    .i_ready(ready0), .o_parity_err(perr0), .o_frame_err(ferr0),
    .o_overrun(ovr0), .o_busy(busy0)
  );

  uart_rx_param #(.BAUD_DIV(4), .OVERSAMPLE(8), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_rx_d(rx1), .o_data(data1), .o_valid(valid1),
    .i_ready(ready1), .o_parity_err(perr1), .o_frame_err(ferr1),
    .o_overrun(ovr1), .o_busy(busy1)
  );

  // Record every accepted word and every overrun pulse
  logic [7:0] cap0_data;
  logic [6:0] cap1_data;
  logic       cap0_perr, cap0_ferr, cap1_perr, cap1_ferr;
  int         acc0 = 0, acc1 = 0, ovr0_cnt = 0, ovr1_cnt = 0;

  always @(negedge clk) begin
    if (valid0 && ready0) begin
      cap0_data <= data0;
      cap0_perr <= perr0;
      cap0_ferr <= ferr0;
      acc0      <= acc0 + 1;
    end
    if (valid1 && ready1) begin
      cap1_data <= data1;
      cap1_perr <= perr1;
      cap1_ferr <= ferr1;
      acc1      <= acc1 + 1;
    end
    if (ovr0) ovr0_cnt <= ovr0_cnt + 1;
    if (ovr1) ovr1_cnt <= ovr1_cnt + 1;
  end

  task automatic send0(input logic [7:0] d, input logic stop_bit);
    rx0 = 1'b0;
    repeat (BIT0) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx0 = d[i];
      repeat (BIT0) @(negedge clk);
    end
    rx0 = stop_bit;
    repeat (BIT0) @(negedge clk);
    rx0 = 1'b1;
  endtask

  task automatic send1(input logic [6:0] d, input logic inv_par);
    rx1 = 1'b0;
    repeat (BIT1) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      rx1 = d[i];
      repeat (BIT1) @(negedge clk);
    end
    rx1 = (^d) ^ inv_par;
    repeat (BIT1) @(negedge clk);
    rx1 = 1'b1;
    repeat (BIT1) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1; ready0 = 1'b1; ready1 = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if ({data0, valid0, perr0, ferr0, ovr0, busy0} !== 13'd0) begin
      bad++; $display("FAIL reset_dut0: got %h want 0", {data0, valid0, perr0, ferr0, ovr0, busy0});
    end
    total++;
    if ({data1, valid1, perr1, ferr1, ovr1, busy1} !== 12'd0) begin
      bad++; $display("FAIL reset_dut1: got %h want 0", {data1, valid1, perr1, ferr1, ovr1, busy1});
    end
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
  endtask

  task automatic test_basic;
    int a, o;
    a = acc0; o = ovr0_cnt;
    send0(8'hA5, 1'b1);
    repeat (200) @(negedge clk);
    total++;
    if (acc0 !== a + 1) begin bad++; $display("FAIL basic_count: got %0d want %0d", acc0, a + 1); end
    total++;
    if (cap0_data !== 8'hA5) begin bad++; $display("FAIL basic_data: got %h want a5", cap0_data); end
    total++;
    if ({cap0_perr, cap0_ferr} !== 2'b00) begin
      bad++; $display("FAIL basic_flags: got %b want 00", {cap0_perr, cap0_ferr});
    end
    total++;
    if (ovr0_cnt !== o) begin bad++; $display("FAIL basic_overrun: got %0d want %0d", ovr0_cnt, o); end
    total++;
    if (valid0 !== 1'b0) begin bad++; $display("FAIL basic_valid_low: got %b want 0", valid0); end
  endtask

  task automatic test_parity;
    int a;
    a = acc1;
    send1(7'h35, 1'b0);
    repeat (40) @(negedge clk);
    total++;
    if (acc1 !== a + 1) begin bad++; $display("FAIL par_good_count: got %0d want %0d", acc1, a + 1); end
    total++;
    if ({cap1_data, cap1_perr, cap1_ferr} !== {7'h35, 2'b00}) begin
      bad++; $display("FAIL par_good_word: got %h/%b%b want 35/00", cap1_data, cap1_perr, cap1_ferr);
    end
    send1(7'h35, 1'b1);
    repeat (40) @(negedge clk);
    total++;
    if (acc1 !== a + 2) begin bad++; $display("FAIL par_bad_count: got %0d want %0d", acc1, a + 2); end
    total++;
    if ({cap1_data, cap1_perr, cap1_ferr} !== {7'h35, 2'b10}) begin
      bad++; $display("FAIL par_bad_word: got %h/%b%b want 35/10", cap1_data, cap1_perr, cap1_ferr);
    end
  endtask

  task automatic test_frame_err;
    int a;
    a = acc0;
    send0(8'h3C, 1'b0);
    repeat (600) @(negedge clk);
    total++;
    if (acc0 !== a + 1) begin bad++; $display("FAIL ferr_count: got %0d want %0d", acc0, a + 1); end
    total++;
    if ({cap0_data, cap0_perr, cap0_ferr} !== {8'h3C, 2'b01}) begin
      bad++; $display("FAIL ferr_word: got %h/%b%b want 3c/01", cap0_data, cap0_perr, cap0_ferr);
    end
    send0(8'h11, 1'b1);
    repeat (200) @(negedge clk);
    total++;
    if (acc0 !== a + 2) begin bad++; $display("FAIL ferr_next_count: got %0d want %0d", acc0, a + 2); end
    total++;
    if ({cap0_data, cap0_perr, cap0_ferr} !== {8'h11, 2'b00}) begin
      bad++; $display("FAIL ferr_next_word: got %h/%b%b want 11/00", cap0_data, cap0_perr, cap0_ferr);
    end
  endtask

  task automatic test_glitch;
    int a;
    a = acc0;
    rx0 = 1'b0;
    repeat (4 * 27) @(negedge clk);
    rx0 = 1'b1;
    repeat (BIT0) @(negedge clk);
    total++;
    if (busy0 !== 1'b0) begin bad++; $display("FAIL glitch_busy: got %b want 0", busy0); end
    total++;
    if (acc0 !== a || valid0 !== 1'b0) begin
      bad++; $display("FAIL glitch_no_word: got count %0d valid %b want %0d/0", acc0, valid0, a);
    end
    repeat (2 * BIT0) @(negedge clk);
    send0(8'h5A, 1'b1);
    repeat (200) @(negedge clk);
    total++;
    if (acc0 !== a + 1) begin bad++; $display("FAIL glitch_next_count: got %0d want %0d", acc0, a + 1); end
    total++;
    if ({cap0_data, cap0_perr, cap0_ferr} !== {8'h5A, 2'b00}) begin
      bad++; $display("FAIL glitch_next_word: got %h/%b%b want 5a/00", cap0_data, cap0_perr, cap0_ferr);
    end
  endtask

  task automatic test_back_to_back;
    int a, o;
    a = acc0; o = ovr0_cnt;
    ready0 = 1'b0;
    send0(8'h01, 1'b1);
    send0(8'h02, 1'b1);
    repeat (200) @(negedge clk);
    total++;
    if (valid0 !== 1'b1 || data0 !== 8'h01) begin
      bad++; $display("FAIL b2b_hold: got valid %b data %h want 1/01", valid0, data0);
    end
    total++;
    if (ovr0_cnt !== o + 1) begin bad++; $display("FAIL b2b_overrun: got %0d want %0d", ovr0_cnt, o + 1); end
    total++;
    if (acc0 !== a) begin bad++; $display("FAIL b2b_no_accept: got %0d want %0d", acc0, a); end
    @(posedge clk);
    #1 ready0 = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (acc0 !== a + 1 || cap0_data !== 8'h01) begin
      bad++; $display("FAIL b2b_consume: got count %0d data %h want %0d/01", acc0, cap0_data, a + 1);
    end
    total++;
    if (valid0 !== 1'b0) begin bad++; $display("FAIL b2b_valid_fall: got %b want 0", valid0); end
  endtask

  task automatic test_reset_mid_frame;
    int a;
    rx0 = 1'b0;
    repeat (5 * BIT0) @(negedge clk);
    rx0 = 1'b1;
    repeat (BIT0 / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if ({data0, valid0, perr0, ferr0, ovr0, busy0} !== 13'd0) begin
      bad++; $display("FAIL midrst_outputs: got %h want 0", {data0, valid0, perr0, ferr0, ovr0, busy0});
    end
    a = acc0;
    rst_n = 1'b1;
    repeat (10 * BIT0) @(negedge clk);
    total++;
    if ({valid0, perr0, ferr0, busy0} !== 4'd0 || acc0 !== a) begin
      bad++; $display("FAIL midrst_quiet: got %b count %0d want 0000/%0d", {valid0, perr0, ferr0, busy0}, acc0, a);
    end
    send0(8'hC3, 1'b1);
    repeat (200) @(negedge clk);
    total++;
    if (acc0 !== a + 1) begin bad++; $display("FAIL midrst_next_count: got %0d want %0d", acc0, a + 1); end
    total++;
    if ({cap0_data, cap0_perr, cap0_ferr} !== {8'hC3, 2'b00}) begin
      bad++; $display("FAIL midrst_next_word: got %h/%b%b want c3/00", cap0_data, cap0_perr, cap0_ferr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
